// File: rtl/conv_window_tile_packer.sv
// Walks every convolution window of a padded multi-channel image, fetches in-image pixels
// through the address-redirect handshake and packs each window into whole tile-buffer SRAM words.
module conv_window_tile_packer #(
    parameter int PIX_W        = 4,
    parameter int PIX_PER_WORD = 9,
    parameter int NUM_WMASKS   = 8,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int SRAM_DEPTH   = 1024,
    parameter int COORD_W      = 16,
    parameter int WR_WAIT      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COORD_W-1:0]    CTRL_img_w_full,
    input  logic [COORD_W-1:0]    CTRL_img_h_full,
    input  logic [COORD_W-1:0]    CTRL_img_c_full,
    input  logic [COORD_W-1:0]    CTRL_filter_w,
    input  logic [COORD_W-1:0]    CTRL_filter_h,
    input  logic [COORD_W-1:0]    CTRL_padding_t_full_img,
    input  logic [COORD_W-1:0]    CTRL_padding_b_full_img,
    input  logic [COORD_W-1:0]    CTRL_padding_l_full_img,
    input  logic [COORD_W-1:0]    CTRL_padding_r_full_img,
    input  logic [COORD_W-1:0]    CTRL_stride,
    output logic                  busy,
    output logic                  done,
    output logic [COORD_W-1:0]    x,
    output logic [COORD_W-1:0]    y,
    output logic [COORD_W-1:0]    z,
    output logic                  data_ready_to_mem_addr_redirect,
    input  logic                  data_ready_from_mem_addr_redirect,
    input  logic [PIX_W-1:0]      pixel_data,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  we,
    output logic                  csb,
    output logic [NUM_WMASKS-1:0] wmask,
    output logic [31:0]           word_count,
    output logic                  wrap
);
    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int WCNT_W = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
    localparam int PACK_W = PIX_PER_WORD * PIX_W;
    localparam logic signed [COORD_W-1:0] ONE  = 1;
    localparam logic signed [COORD_W-1:0] ZERO = 0;

    typedef enum logic [2:0] {S_IDLE, S_ELEM, S_FETCH, S_WR, S_WWAIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic signed [COORD_W-1:0] cfg_w, cfg_h, cfg_c, cfg_fw, cfg_fh, cfg_t, cfg_l, cfg_s;
    logic signed [COORD_W-1:0] out_w, out_h, ch, oy, ox, ky, kx;
    logic signed [COORD_W-1:0] span_w, span_h, s_in, ow_calc, oh_calc, row, col;
    logic [LANE_W-1:0]         lane;
    logic [PACK_W-1:0]         pack;
    logic [WCNT_W-1:0]         wcnt;
    logic                      pass_last, start_empty, in_img, last_kx, last_elem, last_win;
    logic                      fetch_ack, elem_take, word_end, wait_end;
    logic [PIX_W-1:0]          lane_val;

    // Output geometry from the live CTRL inputs; a negative span means no window fits at all.
    assign s_in   = $signed(CTRL_stride);
    assign span_w = $signed(CTRL_img_w_full) + $signed(CTRL_padding_l_full_img)
                  + $signed(CTRL_padding_r_full_img) - $signed(CTRL_filter_w);
    assign span_h = $signed(CTRL_img_h_full) + $signed(CTRL_padding_t_full_img)
                  + $signed(CTRL_padding_b_full_img) - $signed(CTRL_filter_h);
    assign ow_calc = (span_w < 0 || s_in < 1) ? ZERO : span_w / s_in + ONE;
    assign oh_calc = (span_h < 0 || s_in < 1) ? ZERO : span_h / s_in + ONE;
    assign start_empty = (ow_calc < 1) || (oh_calc < 1) || ($signed(CTRL_img_c_full) < 1);

    assign row       = oy * cfg_s + ky - cfg_t;
    assign col       = ox * cfg_s + kx - cfg_l;
    assign in_img    = (row >= 0) && (row < cfg_h) && (col >= 0) && (col < cfg_w);
    assign last_kx   = (kx == cfg_fw - ONE);
    assign last_elem = last_kx && (ky == cfg_fh - ONE);
    assign last_win  = (ox == out_w - ONE) && (oy == out_h - ONE) && (ch == cfg_c - ONE);
    assign fetch_ack = (state == S_FETCH) && data_ready_from_mem_addr_redirect;
    assign elem_take = ((state == S_ELEM) && !in_img) || fetch_ack;
    assign word_end  = (lane == LANE_W'(PIX_PER_WORD - 1)) || last_elem;
    assign wait_end  = (wcnt == WCNT_W'(WR_WAIT - 1));
    assign lane_val  = fetch_ack ? pixel_data : '0;

    assign busy  = (state != S_IDLE) && (state != S_DONE);
    assign done  = (state == S_DONE);
    assign wmask = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = start_empty ? S_DONE : S_ELEM;
            S_ELEM:  if (in_img) state_nxt = S_FETCH;
                     else if (word_end) state_nxt = S_WR;
            S_FETCH: if (fetch_ack) state_nxt = word_end ? S_WR : S_ELEM;
            S_WR:    state_nxt = S_WWAIT;
            S_WWAIT: if (wait_end) state_nxt = pass_last ? S_DONE : S_ELEM;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {cfg_w, cfg_h, cfg_c, cfg_fw, cfg_fh, cfg_t, cfg_l, cfg_s} <= '0;
            {out_w, out_h, ch, oy, ox, ky, kx} <= '0;
            lane <= '0; pack <= '0; wcnt <= '0; pass_last <= 1'b0;
            x <= '0; y <= '0; z <= '0;
            data_ready_to_mem_addr_redirect <= 1'b0;
            addr <= '0; data_in <= '0; we <= 1'b1; csb <= 1'b1;
            word_count <= '0; wrap <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cfg_w <= $signed(CTRL_img_w_full);  cfg_h <= $signed(CTRL_img_h_full);
                    cfg_c <= $signed(CTRL_img_c_full);  cfg_fw <= $signed(CTRL_filter_w);
                    cfg_fh <= $signed(CTRL_filter_h);   cfg_t <= $signed(CTRL_padding_t_full_img);
                    cfg_l <= $signed(CTRL_padding_l_full_img); cfg_s <= s_in;
                    out_w <= ow_calc; out_h <= oh_calc;
                    {ch, oy, ox, ky, kx} <= '0;
                    lane <= '0; pack <= '0; pass_last <= 1'b0;
                    addr <= '0; word_count <= '0; wrap <= 1'b0;
                end
                S_ELEM: if (in_img) begin
                    x <= row; y <= col; z <= ch;
                    data_ready_to_mem_addr_redirect <= 1'b1;
                end
                S_FETCH: if (fetch_ack) data_ready_to_mem_addr_redirect <= 1'b0;
                // Word handoff: the packed lanes move to the SRAM port and the buffer restarts empty.
                S_WR: begin
                    data_in <= '0;
                    data_in[PACK_W-1:0] <= pack;
                    csb <= 1'b0; we <= 1'b0;
                    pack <= '0; wcnt <= '0;
                end
                S_WWAIT: if (wait_end) begin
                    csb <= 1'b1; we <= 1'b1;
                    word_count <= word_count + 32'd1;
                    if (addr == ADDR_WIDTH'(SRAM_DEPTH - 1)) begin
                        addr <= '0; wrap <= 1'b1;
                    end else addr <= addr + ADDR_WIDTH'(1);
                end else wcnt <= wcnt + WCNT_W'(1);
                default: ;
            endcase

            // Element consumed (padded or fetched): store its lane and step the window walk.
            if (elem_take) begin
                pack[lane*PIX_W +: PIX_W] <= lane_val;
                lane <= word_end ? '0 : lane + LANE_W'(1);
                if (last_elem) begin
                    kx <= '0; ky <= '0;
                    if (last_win) pass_last <= 1'b1;
                    if (ox == out_w - ONE) begin
                        ox <= '0;
                        if (oy == out_h - ONE) begin oy <= '0; ch <= ch + ONE; end
                        else oy <= oy + ONE;
                    end else ox <= ox + ONE;
                end else if (last_kx) begin
                    kx <= '0; ky <= ky + ONE;
                end else kx <= kx + ONE;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_tile_packer.sv
// Directed bench for conv_window_tile_packer: three instances (default, 8 lanes/word, 16-word SRAM)
// share CTRL inputs; a memory responder serves pixels and a monitor captures every SRAM write.
module tb_conv_window_tile_packer;
    localparam int N = 3;
    localparam int WR_WAIT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start [N];
    logic [15:0] c_w, c_h, c_c, c_fw, c_fh, c_pt, c_pb, c_pl, c_pr, c_s;
    logic busy [N], done [N], req [N], ack [N], we [N], csb [N], wrap [N], req_q [N];
    logic [15:0] xo [N], yo [N], zo [N], px [N], py [N], pz [N];
    logic [3:0]  pix [N];
    logic [9:0]  addr [N];
    logic [63:0] din [N];
    logic [7:0]  wmask [N];
    logic [31:0] wcnt [N];
    int low_len [N], dly [N], got_n [N], fetch_n [N], viol [N];
    logic [63:0] got_d [N][64];
    logic [9:0]  got_a [N][64];
    logic [63:0] exp_d [64];
    int exp_n, max_dly, checks, failures;

    for (genvar g = 0; g < N; g++) begin : g_dut
        conv_window_tile_packer #(
            .PIX_PER_WORD(g == 1 ? 8 : 9), .SRAM_DEPTH(g == 2 ? 16 : 1024)
        ) dut (
            .clk(clk), .rst(rst), .start(start[g]),
            .CTRL_img_w_full(c_w), .CTRL_img_h_full(c_h), .CTRL_img_c_full(c_c),
            .CTRL_filter_w(c_fw), .CTRL_filter_h(c_fh),
            .CTRL_padding_t_full_img(c_pt), .CTRL_padding_b_full_img(c_pb),
            .CTRL_padding_l_full_img(c_pl), .CTRL_padding_r_full_img(c_pr),
            .CTRL_stride(c_s), .busy(busy[g]), .done(done[g]),
            .x(xo[g]), .y(yo[g]), .z(zo[g]),
            .data_ready_to_mem_addr_redirect(req[g]),
            .data_ready_from_mem_addr_redirect(ack[g]), .pixel_data(pix[g]),
            .addr(addr[g]), .data_in(din[g]), .we(we[g]), .csb(csb[g]), .wmask(wmask[g]),
            .word_count(wcnt[g]), .wrap(wrap[g])
        );
    end

    function automatic logic [3:0] pixval(input int r, input int c, input int ch, input int w);
        return 4'(r * w + c + 1 + ch * 7);
    endfunction

    // Responder and write monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (start[i] && !busy[i]) begin got_n[i] = 0; fetch_n[i] = 0; viol[i] = 0; end
            if (!rst) begin
                low_len[i] = 0; ack[i] = 1'b0; dly[i] = 0;
            end else begin
                if (!csb[i]) begin
                    if (low_len[i] == 0 && got_n[i] < 64) begin
                        got_d[i][got_n[i]] = din[i]; got_a[i][got_n[i]] = addr[i]; got_n[i]++;
                    end
                    low_len[i]++;
                    if (req[i] || we[i]) viol[i]++;
                end else begin
                    if (low_len[i] != 0 && low_len[i] != WR_WAIT) viol[i]++;
                    low_len[i] = 0;
                    if (!we[i]) viol[i]++;
                end
                if (req[i] && req_q[i] && (xo[i] != px[i] || yo[i] != py[i] || zo[i] != pz[i])) viol[i]++;
                if (ack[i]) begin
                    ack[i] = 1'b0; dly[i] = int'($urandom_range(max_dly, 0));
                end else if (req[i]) begin
                    if (dly[i] == 0) begin
                        ack[i] = 1'b1; fetch_n[i]++;
                        pix[i] = pixval(int'(xo[i]), int'(yo[i]), int'(zo[i]), int'(c_w));
                    end else dly[i]--;
                end
            end
            px[i] = xo[i]; py[i] = yo[i]; pz[i] = zo[i]; req_q[i] = req[i];
        end
    end

    task automatic set_cfg(input int w, h, c, fw, fh, pad, s);
        c_w = 16'(w); c_h = 16'(h); c_c = 16'(c); c_fw = 16'(fw); c_fh = 16'(fh);
        c_pt = 16'(pad); c_pb = 16'(pad); c_pl = 16'(pad); c_pr = 16'(pad); c_s = 16'(s);
    endtask

    task automatic build_exp(input int ppw, w, h, c, fw, fh, pad, s);
        int ow, oh, lane, r, cc;
        logic [63:0] word;
        exp_n = 0;
        ow = (w + 2 * pad - fw) / s + 1;
        oh = (h + 2 * pad - fh) / s + 1;
        for (int ch = 0; ch < c; ch++)
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++) begin
                    word = '0; lane = 0;
                    for (int ky = 0; ky < fh; ky++)
                        for (int kx = 0; kx < fw; kx++) begin
                            r = oy * s + ky - pad; cc = ox * s + kx - pad;
                            if (r >= 0 && r < h && cc >= 0 && cc < w) word[lane*4 +: 4] = pixval(r, cc, ch, w);
                            lane++;
                            if (lane == ppw) begin exp_d[exp_n] = word; exp_n++; word = '0; lane = 0; end
                        end
                    if (lane != 0) begin exp_d[exp_n] = word; exp_n++; end
                end
    endtask

    task automatic run_pass(input int sel, input int w, h, c, fw, fh, pad, s, input int restart_at);
        bit ok;
        set_cfg(w, h, c, fw, fh, pad, s);
        @(posedge clk); #1 start[sel] = 1'b1;
        @(posedge clk); #1 start[sel] = 1'b0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (done[sel]) begin ok = 1'b1; break; end
            start[sel] = (cyc == restart_at);
            if (cyc == restart_at) begin c_fw = 16'd2; c_s = 16'd2; end
            @(posedge clk); #1;
        end
        start[sel] = 1'b0;
        set_cfg(w, h, c, fw, fh, pad, s);
        checks++;
        if (!ok) begin failures++; $display("FAIL pass_timeout sel=%0d done never seen within budget", sel); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy[0], done[0], req[0], csb[0], we[0], wrap[0]} !== 6'b000110) begin
            failures++; $display("FAIL reset_ctrl got=%b want=000110", {busy[0], done[0], req[0], csb[0], we[0], wrap[0]});
        end
        checks++;
        if (addr[0] !== 10'd0 || din[0] !== 64'd0 || wcnt[0] !== 32'd0 || xo[0] !== 16'd0) begin
            failures++; $display("FAIL reset_data addr=%0d din=%h wc=%0d x=%0d want all 0", addr[0], din[0], wcnt[0], xo[0]);
        end
        checks++;
        if (wmask[0] !== 8'hFF) begin failures++; $display("FAIL reset_wmask got=%h want=ff", wmask[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy[0]); end
    endtask

    task automatic test_padded_window;
        run_pass(0, 4, 4, 1, 3, 3, 1, 1, -1);
        build_exp(9, 4, 4, 1, 3, 3, 1, 1);
        checks++;
        if (got_n[0] !== 16 || wcnt[0] !== 32'd16) begin
            failures++; $display("FAIL t1_words got=%0d wc=%0d want=16", got_n[0], wcnt[0]);
        end
        checks++;
        if (got_d[0][0] !== 64'h0000_0006_5021_0000) begin
            failures++; $display("FAIL t1_word0 got=%h want=0000000650210000", got_d[0][0]);
        end
        for (int k = 0; k < exp_n && k < got_n[0]; k++) begin
            checks++;
            if (got_d[0][k] !== exp_d[k] || got_a[0][k] !== 10'(k)) begin
                failures++; $display("FAIL t1_word%0d got=%h@%0d want=%h@%0d", k, got_d[0][k], got_a[0][k], exp_d[k], k);
            end
        end
        checks++;
        if (fetch_n[0] !== 100 || addr[0] !== 10'd16 || wrap[0] !== 1'b0 || viol[0] !== 0) begin
            failures++; $display("FAIL t1_status fetch=%0d addr=%0d wrap=%b viol=%0d want 100/16/0/0", fetch_n[0], addr[0], wrap[0], viol[0]);
        end
    endtask

    task automatic test_stride;
        run_pass(0, 5, 5, 1, 3, 3, 0, 2, -1);
        build_exp(9, 5, 5, 1, 3, 3, 0, 2);
        checks++;
        if (got_n[0] !== 4 || fetch_n[0] !== 36) begin
            failures++; $display("FAIL t2_counts words=%0d fetch=%0d want 4/36", got_n[0], fetch_n[0]);
        end
        checks++;
        if (got_d[0][1] !== 64'h0000_000F_EDA9_8543 || got_a[0][1] !== 10'd1) begin
            failures++; $display("FAIL t2_word1 got=%h@%0d want=0000000feda98543@1", got_d[0][1], got_a[0][1]);
        end
        for (int k = 0; k < exp_n && k < got_n[0]; k++) begin
            checks++;
            if (got_d[0][k] !== exp_d[k]) begin
                failures++; $display("FAIL t2_word%0d got=%h want=%h", k, got_d[0][k], exp_d[k]);
            end
        end
    endtask

    task automatic test_multi_word;
        run_pass(1, 5, 5, 1, 3, 3, 0, 2, -1);
        build_exp(8, 5, 5, 1, 3, 3, 0, 2);
        checks++;
        if (got_n[1] !== 8 || wcnt[1] !== 32'd8) begin
            failures++; $display("FAIL t3_words got=%0d wc=%0d want=8", got_n[1], wcnt[1]);
        end
        checks++;
        if (got_d[1][1] !== 64'hD || got_d[1][3] !== 64'hF) begin
            failures++; $display("FAIL t3_tail w1=%h w3=%h want d/f", got_d[1][1], got_d[1][3]);
        end
        for (int k = 0; k < exp_n && k < got_n[1]; k++) begin
            checks++;
            if (got_d[1][k] !== exp_d[k]) begin
                failures++; $display("FAIL t3_word%0d got=%h want=%h", k, got_d[1][k], exp_d[k]);
            end
        end
    endtask

    task automatic test_wrap;
        run_pass(2, 4, 4, 1, 3, 3, 1, 1, -1);
        checks++;
        if (addr[2] !== 10'd0 || wrap[2] !== 1'b1 || wcnt[2] !== 32'd16) begin
            failures++; $display("FAIL t4_wrap addr=%0d wrap=%b wc=%0d want 0/1/16", addr[2], wrap[2], wcnt[2]);
        end
        run_pass(2, 4, 4, 2, 3, 3, 1, 1, -1);
        build_exp(9, 4, 4, 2, 3, 3, 1, 1);
        checks++;
        if (got_n[2] !== 32 || wcnt[2] !== 32'd32 || addr[2] !== 10'd0 || wrap[2] !== 1'b1) begin
            failures++; $display("FAIL t4_two_ch words=%0d wc=%0d addr=%0d wrap=%b want 32/32/0/1", got_n[2], wcnt[2], addr[2], wrap[2]);
        end
        for (int k = 0; k < exp_n && k < got_n[2]; k++) begin
            checks++;
            if (got_d[2][k] !== exp_d[k] || got_a[2][k] !== 10'(k % 16)) begin
                failures++; $display("FAIL t4_word%0d got=%h@%0d want=%h@%0d", k, got_d[2][k], got_a[2][k], exp_d[k], k % 16);
            end
        end
    endtask

    task automatic test_slow_ack;
        max_dly = 5;
        run_pass(0, 4, 4, 1, 3, 3, 1, 1, 20);
        max_dly = 0;
        build_exp(9, 4, 4, 1, 3, 3, 1, 1);
        checks++;
        if (got_n[0] !== 16 || fetch_n[0] !== 100 || viol[0] !== 0) begin
            failures++; $display("FAIL t5_status words=%0d fetch=%0d viol=%0d want 16/100/0", got_n[0], fetch_n[0], viol[0]);
        end
        for (int k = 0; k < exp_n && k < got_n[0]; k++) begin
            checks++;
            if (got_d[0][k] !== exp_d[k]) begin
                failures++; $display("FAIL t5_word%0d got=%h want=%h", k, got_d[0][k], exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid_pass;
        bit seen;
        max_dly = 3;
        set_cfg(4, 4, 1, 3, 3, 1, 1);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(posedge clk); #1;
            seen = req[0];
        end
        rst = 1'b0; #1;
        checks++;
        if (!seen || req[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++; $display("FAIL t6_fetch_rst seen=%b req=%b busy=%b want 1/0/0", seen, req[0], busy[0]);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(posedge clk); #1;
            seen = !csb[0];
        end
        rst = 1'b0; #1;
        checks++;
        if (!seen || csb[0] !== 1'b1 || we[0] !== 1'b1 || busy[0] !== 1'b0 || addr[0] !== 10'd0) begin
            failures++; $display("FAIL t6_wr_rst seen=%b csb=%b we=%b busy=%b addr=%0d want 1/1/1/0/0", seen, csb[0], we[0], busy[0], addr[0]);
        end
        @(posedge clk); #1 rst = 1'b1;
        max_dly = 0;
        run_pass(0, 4, 4, 1, 3, 3, 1, 1, -1);
        build_exp(9, 4, 4, 1, 3, 3, 1, 1);
        checks++;
        if (got_n[0] !== 16 || addr[0] !== 10'd16) begin
            failures++; $display("FAIL t6_rerun words=%0d addr=%0d want 16/16", got_n[0], addr[0]);
        end
        for (int k = 0; k < exp_n && k < got_n[0]; k++) begin
            checks++;
            if (got_d[0][k] !== exp_d[k] || got_a[0][k] !== 10'(k)) begin
                failures++; $display("FAIL t6_word%0d got=%h@%0d want=%h@%0d", k, got_d[0][k], got_a[0][k], exp_d[k], k);
            end
        end
        run_pass(0, 4, 4, 1, 6, 3, 0, 1, -1);
        checks++;
        if (wcnt[0] !== 32'd0 || got_n[0] !== 0 || addr[0] !== 10'd0) begin
            failures++; $display("FAIL t6_empty wc=%0d words=%0d addr=%0d want 0/0/0", wcnt[0], got_n[0], addr[0]);
        end
    endtask

    initial begin
        checks = 0; failures = 0; max_dly = 0;
        for (int i = 0; i < N; i++) start[i] = 1'b0;
        set_cfg(4, 4, 1, 3, 3, 1, 1);
        test_reset;
        test_padded_window;
        test_stride;
        test_multi_word;
        test_wrap;
        test_slow_ack;
        test_reset_mid_pass;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
